// File: rtl/popcount_scheduler.sv
// Round-robin share of one combinational 4-input one-hot popcount unit; one nibble per cycle, result WORD_W/4+1 cycles after grant.
// Result held in DONE until res_ready; no grant until back in IDLE. Optional ONEHOT_CHECK_EN flags non-one-hot counter results.
module popcount_scheduler #(
  parameter int NREQ   = 2,
  parameter int WORD_W = 16,
  localparam int CW    = $clog2(WORD_W + 1),
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic                     cnt_a,
  output logic                     cnt_b,
  output logic                     cnt_c,
  output logic                     cnt_d,
  input  logic                     cnt_v,
  input  logic                     cnt_w,
  input  logic                     cnt_x,
  input  logic                     cnt_y,
  input  logic                     cnt_z,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CW-1:0]            res_count,
  output logic [IW-1:0]            res_id,
  output logic                     res_err
);

  localparam int NIB = WORD_W / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       state;
  logic [IW-1:0]                rr_ptr;
  logic [NIB-1:0][3:0]          word;
  logic [NW-1:0]                nib;
  logic [CW-1:0]                acc;
  logic [IW-1:0]                id;
  logic                         err;

  logic [NREQ-1:0][WORD_W-1:0]  req_words;
  logic                         gnt_found;
  logic [IW-1:0]                gnt_idx;
  logic [IW:0]                  sum;
  logic [4:0]                   res_vec;
  logic [2:0]                   dec;
  logic                         bad;

  assign req_words = req_data;
  assign res_vec   = {cnt_z, cnt_y, cnt_x, cnt_w, cnt_v};

  // First valid requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!gnt_found && req_valid[sum[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[IW-1:0];
      end
    end
  end

`ifdef ONEHOT_CHECK_EN
  always_comb begin
    dec = 3'd0;
    bad = 1'b0;
    case (res_vec)
      5'b00001: dec = 3'd0;
      5'b00010: dec = 3'd1;
      5'b00100: dec = 3'd2;
      5'b01000: dec = 3'd3;
      5'b10000: dec = 3'd4;
      default:  bad = 1'b1;
    endcase
  end
`else
  always_comb begin
    dec = 3'd0;
    bad = 1'b0;
    casez (res_vec)
      5'b1????: dec = 3'd4;
      5'b01???: dec = 3'd3;
      5'b001??: dec = 3'd2;
      5'b0001?: dec = 3'd1;
      default:  dec = 3'd0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      word   <= '0;
      nib    <= '0;
      acc    <= '0;
      id     <= '0;
      err    <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            word   <= req_words[gnt_idx];
            id     <= gnt_idx;
            acc    <= '0;
            err    <= 1'b0;
            nib    <= '0;
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc + CW'(dec);
          err <= err | bad;
          if (nib == NW'(NIB - 1)) state <= S_DONE;
          else                     nib   <= nib + 1'b1;
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Grant is combinational so a requester that drops valid is never accepted.
  assign req_ready = (!rst && ena && state == S_IDLE && gnt_found) ?
                     (NREQ'(1) << gnt_idx) : '0;

  assign {cnt_d, cnt_c, cnt_b, cnt_a} = (state == S_RUN) ? word[nib] : 4'b0000;

  assign res_valid = (state == S_DONE);
  assign res_count = acc;
  assign res_id    = id;
  assign res_err   = err;

endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed bench for popcount_scheduler with a behavioural one-hot counter and an override hook.
module tb_popcount_scheduler;

  logic        clk = 1'b0;
  logic        rst, ena, res_ready;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        cnt_a, cnt_b, cnt_c, cnt_d;
  logic        cnt_v, cnt_w, cnt_x, cnt_y, cnt_z;
  logic        res_valid, res_err;
  logic [4:0]  res_count;
  logic [0:0]  res_id;

  logic        ovr;
  logic [2:0]  pc;
  logic [4:0]  vec;
  logic [3:0]  cnt_nib;

  int vecs = 0;
  int miss = 0;
  int n;
  logic seen;
  logic [4:0] exp_cnt;
  logic       exp_err;

  always #5 clk = ~clk;

  popcount_scheduler #(.NREQ(2), .WORD_W(16)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d),
    .cnt_v(cnt_v), .cnt_w(cnt_w), .cnt_x(cnt_x), .cnt_y(cnt_y), .cnt_z(cnt_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_id(res_id), .res_err(res_err)
  );

  // Shared counter: one-hot of the number of ones, or a forced w+x pair.
  assign cnt_nib = {cnt_d, cnt_c, cnt_b, cnt_a};
  always_comb begin
    pc  = 3'(cnt_a) + 3'(cnt_b) + 3'(cnt_c) + 3'(cnt_d);
    vec = 5'b00001 << pc;
    if (ovr) vec = 5'b00110;
  end
  assign {cnt_z, cnt_y, cnt_x, cnt_w, cnt_v} = vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("res_valid_arrives", res_valid, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_cnt"}, cnt_nib, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_err"}, res_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ONEHOT_CHECK_EN
    exp_cnt = 5'd4; exp_err = 1'b1;
`else
    exp_cnt = 5'd6; exp_err = 1'b0;
`endif
    rst = 1'b1; ena = 1'b1; req_valid = 2'b00; req_data = '0; res_ready = 1'b0; ovr = 1'b0;
    step(); step();
    chk_reset_outputs("reset");

    // req0 0xFFFF: handshake at T, result at T+5
    rst = 1'b0;
    req_data[15:0] = 16'hFFFF;
    req_valid = 2'b01;
    #1;
    chk("t1_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      chk("t1_run_nibble", cnt_nib, 4'hF);
      chk("t1_run_novalid", res_valid, 0);
      step();
    end
    chk("t1_res_valid_T5", res_valid, 1);
    chk("t1_count", res_count, 16);
    chk("t1_id", res_id, 0);
    chk("t1_err", res_err, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t1_back_idle", res_valid, 0);

    // req1 0x0000: nibbles all zero
    req_data[31:16] = 16'h0000;
    req_valid = 2'b10;
    #1;
    chk("t2_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      chk("t2_run_nibble", cnt_nib, 4'h0);
      step();
    end
    chk("t2_res_valid", res_valid, 1);
    chk("t2_count", res_count, 0);
    chk("t2_id", res_id, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Round robin with both requesters valid continuously
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_data = {16'h7001, 16'h8421};
    req_valid = 2'b11;
    res_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_valid(n);
      chk("rr_latency", n, 5);
      chk("rr_id", res_id, (r == 1) ? 1 : 0);
      chk("rr_count", res_count, 4);
      step();
    end
    req_valid = 2'b00;
    res_ready = 1'b0;

    // Backpressure in DONE for 10 cycles
    req_data[15:0] = 16'h1234;
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    wait_valid(n);
    chk("bp_latency", n, 4);
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", {res_valid, req_ready, res_count, res_id}, 9'b1_00_00101_0);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_no_grant_in_done", req_ready, 0);
    step();
    req_valid = 2'b00;
    res_ready = 1'b0;
    #1;
    chk("bp_idle", res_valid, 0);
    step();
    chk("bp_single_transfer", res_valid, 0);

    // ena low in IDLE blocks the grant
    ena = 1'b0;
    req_data[15:0] = 16'h00F3;
    req_valid = 2'b01;
    #1;
    chk("ena_idle_no_grant", req_ready, 0);
    step();
    ena = 1'b1;
    #1;
    chk("ena_idle_grant", req_ready, 2'b01);

    // ena low for 3 cycles mid-RUN on 0x00F3
    step();
    req_valid = 2'b00;
    chk("ena_nib0", cnt_nib, 4'h3);
    step();
    chk("ena_nib1", cnt_nib, 4'hF);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ena_frozen", {res_valid, cnt_nib}, 5'h0F);
    end
    ena = 1'b1;
    wait_valid(n);
    chk("ena_delay", n, 3);
    chk("ena_count", res_count, 6);
    chk("ena_err", res_err, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // rst mid-RUN aborts the word and resets rr_ptr
    req_data[15:0] = 16'hFFFF;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    chk("rst_pre_nib", cnt_nib, 4'hF);
    rst = 1'b1;
    step();
    chk_reset_outputs("midrun_rst");
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen = seen | res_valid;
    end
    chk("rst_no_result", seen, 0);

    // Forced w+x on the first nibble of 0x0F0F
    req_data[15:0] = 16'h0F0F;
    req_valid = 2'b11;
    #1;
    chk("rst_rr_ptr", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    ovr = 1'b1;
    step();
    ovr = 1'b0;
    wait_valid(n);
    chk("force_latency", n, 3);
    chk("force_count", res_count, exp_cnt);
    chk("force_err", res_err, exp_err);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("force_released", res_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
